muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
Parameters: none. Operand width is fixed at 32 bits.
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only while busy=0.
REQ-005 op  input  2  operation select: 00 multu, 01 mult, 10 divu, 11 div.
REQ-006 a  input  32  multiplicand or dividend (the datapath's srca).
REQ-007 b  input  32  multiplier or divisor (the datapath's srcb).
REQ-008 wlo  input  1  direct write of wdata into LO (mtlo).
REQ-009 whi  input  1  direct write of wdata into HI (mthi).
REQ-010 wdata  input  32  data for wlo/whi.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse when HI/LO are updated by an operation.
REQ-013 lo  output  32  LO register: product[31:0] or quotient.
REQ-014 hi  output  32  HI register: product[63:32] or remainder.

Function
REQ-015 States SHALL be IDLE and RUN, with an iteration counter of 0..32.
REQ-016 In IDLE, start=1 at edge E0 SHALL do all of the following:
- latch op, |a| and |b| (magnitudes for signed ops, raw values for unsigned ops);
- latch the result sign flags;
- clear the counter;
- enter RUN, with busy=1 after E0.
REQ-017 RUN SHALL perform one radix-2 iteration per edge, E1..E32:
- multiply: shift-add on a 64-bit accumulator;
- divide: restoring shift-subtract on a 64-bit remainder/quotient pair.
REQ-018 At edge E33 the block SHALL:
- apply sign correction (two's-complement negate where required);
- write HI and LO;
- return to IDLE.
REQ-019 done SHALL be 1 for exactly the cycle following E33, and busy SHALL be 0 in that cycle; fixed latency is 33 edges from start to result, independent of operand values.
REQ-020 HI and LO SHALL hold their previous values throughout RUN; there are no partial results on the outputs.
REQ-021 mult SHALL produce the full signed 64-bit product; multu SHALL produce the unsigned 64-bit product.
REQ-022 div SHALL truncate the quotient toward zero, and the remainder SHALL take the sign of the dividend.
REQ-023 div of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000.
REQ-024 Divide by zero (divu or div) SHALL give lo=0xFFFFFFFF and hi=a, with the same 33-edge latency and done asserted.
REQ-025 start while busy=1 SHALL be ignored; the operation is not queued.
REQ-026 start in the done cycle SHALL be accepted, since busy=0 in that cycle.
REQ-027 wlo/whi while busy=1 SHALL be ignored.
REQ-028 In IDLE, wlo/whi SHALL update the register at the edge; wlo and whi together SHALL write both registers.
REQ-029 start together with wlo/whi in IDLE: start SHALL win and the writes SHALL be dropped.
REQ-030 Operands a, b and op SHALL be don't-care after E0; changing them during RUN SHALL NOT affect the result.

Reset
REQ-031 While reset=1 (asynchronous): state=IDLE, counter=0, busy=0, done=0, lo=0x00000000, hi=0x00000000.
REQ-032 Reset during RUN SHALL abort the operation; no done pulse is issued after reset is released.
REQ-033 The first start SHALL be accepted at the first rising edge after reset is deasserted.

Verification
REQ-034 multu a=0xFFFFFFFF, b=0xFFFFFFFF -> at E33: hi=0xFFFFFFFE, lo=0x00000001; done pulse of exactly 1 cycle; busy high for exactly 33 cycles.
REQ-035 mult a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-036 div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-037 div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-038 divu a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
REQ-039 Combined control and reset scenario:
- Stimulus: start a multu 2*3; at E5 pulse start (op=divu) and wlo (wdata=0x1234); at E10 assert reset.
- Response: the E5 requests are ignored; busy=0 and hi=lo=0 immediately on reset; no done pulse.
- Then: wlo (wdata=0x1234) in IDLE gives lo=0x00001234.
- Then: back-to-back start in the done cycle is accepted.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply/divide unit with HI/LO registers.
// Fixed 33-edge latency; radix-2 shift-add multiply and restoring divide on magnitudes.
module muldiv_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        wlo,
   input  logic        whi,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] lo,
   output logic [31:0] hi
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        neg_q, neg_d;     // product / quotient sign
   logic        rneg_q, rneg_d;   // remainder sign
   logic [31:0] opnd_q, opnd_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] lo_q, lo_d, hi_q, hi_d;
   logic        done_q, done_d;

   logic        signed_op;
   logic [31:0] abs_a, abs_b;
   logic [32:0] sum, rsh, rdiff;
   logic        ge;
   logic [63:0] prod;
   logic [31:0] quo, rem;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      done_d   = 1'b0;

      signed_op = op[0];
      abs_a = (signed_op && a[31]) ? (~a + 32'd1) : a;
      abs_b = (signed_op && b[31]) ? (~b + 32'd1) : b;

      sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
      rsh   = {acc_q[63:32], acc_q[31]};
      ge    = (rsh >= {1'b0, opnd_q});
      rdiff = rsh - {1'b0, opnd_q};

      prod = neg_q  ? (~acc_q + 64'd1)         : acc_q;
      quo  = neg_q  ? (~acc_q[31:0] + 32'd1)   : acc_q[31:0];
      rem  = rneg_q ? (~acc_q[63:32] + 32'd1)  : acc_q[63:32];

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               cnt_d    = 6'd0;
               is_div_d = op[1];
               if (op[1]) begin
                  // A zero divisor keeps the all-ones quotient unnegated.
                  neg_d  = signed_op && (a[31] ^ b[31]) && (b != 32'd0);
                  rneg_d = signed_op && a[31];
                  opnd_d = abs_b;
                  acc_d  = {32'd0, abs_a};
               end else begin
                  neg_d  = signed_op && (a[31] ^ b[31]);
                  rneg_d = 1'b0;
                  opnd_d = abs_a;
                  acc_d  = {32'd0, abs_b};
               end
            end else begin
               if (wlo) lo_d = wdata;
               if (whi) hi_d = wdata;
            end
         end
         RUN: begin
            if (cnt_q == 6'd32) begin
               state_d = IDLE;
               done_d  = 1'b1;
               if (is_div_q) begin
                  lo_d = quo;
                  hi_d = rem;
               end else begin
                  lo_d = prod[31:0];
                  hi_d = prod[63:32];
               end
            end else begin
               cnt_d = cnt_q + 6'd1;
               if (is_div_q) begin
                  if (ge) acc_d = {rdiff[31:0], acc_q[30:0], 1'b1};
                  else    acc_d = {rsh[31:0],   acc_q[30:0], 1'b0};
               end else begin
                  acc_d = {sum, acc_q[31:1]};
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 6'd0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         opnd_q   <= 32'd0;
         acc_q    <= 64'd0;
         lo_q     <= 32'd0;
         hi_q     <= 32'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         done_q   <= done_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign lo   = lo_q;
   assign hi   = hi_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus control/reset sequences.
module tb_muldiv_unit;

   logic        clk, reset, start, wlo, whi, busy, done;
   logic [1:0]  op;
   logic [31:0] a, b, wdata, lo, hi;

   int checks = 0;
   int failures = 0;

   muldiv_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .wlo(wlo), .whi(whi), .wdata(wdata),
      .busy(busy), .done(done), .lo(lo), .hi(hi)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_lo;
      logic [31:0] exp_hi;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns just after the accepting edge E0.
   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = $urandom; b = $urandom; op = ~o;
   endtask

   // Returns at the negedge inside the done cycle.
   task automatic wait_result(input string name, input logic [31:0] elo, input logic [31:0] ehi,
                              input logic [31:0] prev_lo, input logic [31:0] prev_hi);
      int busy_cnt = 0;
      bit got = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 10) chk({name, "_hold"}, {hi, lo}, {prev_hi, prev_lo});
         if (busy) busy_cnt++;
         if (done) begin
            got = 1;
            break;
         end
      end
      chk({name, "_done_seen"}, 64'(got), 64'd1);
      chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
      chk({name, "_busy_in_done"}, 64'(busy), 64'd0);
      chk({name, "_result"}, {hi, lo}, {ehi, elo});
   endtask

   initial begin
      logic [31:0] plo, phi;
      int done_cnt;

      vecs[0]  = '{"multu_max",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
      vecs[1]  = '{"mult_m3x5",   2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'hFFFFFFFF};
      vecs[2]  = '{"div_m7_2",    2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF};
      vecs[3]  = '{"div_ovf",     2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
      vecs[4]  = '{"divu_by0",    2'b10, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'h00000007};
      vecs[5]  = '{"div_neg_by0", 2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF9};
      vecs[6]  = '{"div_7_m2",    2'b11, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001};
      vecs[7]  = '{"mult_minmax", 2'b01, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'hC0000000};
      vecs[8]  = '{"multu_shift", 2'b00, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001};
      vecs[9]  = '{"divu_100_7",  2'b10, 32'd100,      32'd7,        32'h0000000E, 32'h00000002};
      vecs[10] = '{"divu_max_1",  2'b10, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
      vecs[11] = '{"div_m8_m3",   2'b11, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'h00000002, 32'hFFFFFFFE};

      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      wlo = 1'b0; whi = 1'b0; wdata = '0;
      #1;
      chk("reset_state", {61'd0, busy, done, 1'b0} ^ {32'd0, 32'd0}, 64'd0);
      chk("reset_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // First vector is issued so that E0 is the first edge after reset release.
      for (int i = 0; i < 12; i++) begin
         plo = lo; phi = hi;
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_result(vecs[i].name, vecs[i].exp_lo, vecs[i].exp_hi, plo, phi);
         @(negedge clk);
         chk({vecs[i].name, "_done_width"}, 64'(done), 64'd0);
      end

      // Requests during RUN are ignored, then reset aborts the operation.
      plo = lo; phi = hi;
      issue(2'b00, 32'd2, 32'd3);
      repeat (4) @(posedge clk);
      @(negedge clk);
      start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd1; wlo = 1'b1; wdata = 32'h1234;
      @(posedge clk);
      #1;
      start = 1'b0; wlo = 1'b0;
      @(negedge clk);
      chk("run_ignore_busy", 64'(busy), 64'd1);
      chk("run_ignore_wlo", {hi, lo}, {phi, plo});
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) done_cnt++;
      end
      chk("abort_no_done", 64'(done_cnt), 64'd0);

      // Direct writes in IDLE.
      wlo = 1'b1; wdata = 32'h1234;
      @(posedge clk);
      #1;
      wlo = 1'b0;
      chk("mtlo_idle", {hi, lo}, {32'h0, 32'h1234});
      @(negedge clk);
      wlo = 1'b1; whi = 1'b1; wdata = 32'hAB;
      @(posedge clk);
      #1;
      wlo = 1'b0; whi = 1'b0;
      chk("mtlo_mthi_both", {hi, lo}, {32'hAB, 32'hAB});

      // Start wins over a simultaneous write.
      @(negedge clk);
      wlo = 1'b1; whi = 1'b1; wdata = 32'h5555;
      issue(2'b00, 32'd2, 32'd3);
      wlo = 1'b0; whi = 1'b0;
      wait_result("start_wins", 32'd6, 32'd0, 32'hAB, 32'hAB);

      // Back-to-back start issued in the done cycle.
      issue(2'b10, 32'd100, 32'd7);
      chk("b2b_accepted", 64'(busy), 64'd1);
      wait_result("b2b", 32'hE, 32'd2, 32'd6, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
